// File: rtl/mem_stage_reg_if.sv
// EX->MEM handoff bundle for mem_stage_reg: EX-side offer/accept, MEM-side entry and decode.
// master = EX/MEM environment side, slave = the stage register itself.
interface mem_stage_reg_if #(
  parameter int TAGW = 8,
  parameter int PCW  = 32
);
  logic            flush;
  logic            E_valid;
  logic            E_ready;
  logic [31:0]     E_I;
  logic [PCW-1:0]  E_PC;
  logic [31:0]     E_AO;
  logic [31:0]     E_RD2;
  logic [TAGW-1:0] E_TAG;
  logic            M_valid;
  logic            M_ready;
  logic [31:0]     M_I;
  logic [PCW-1:0]  M_PC;
  logic [31:0]     M_AO;
  logic [31:0]     M_RD2;
  logic [TAGW-1:0] M_TAG;
  logic [3:0]      M_BE;
  logic [31:0]     M_WD;
  logic            s_w, s_h, s_b, l_w, l_h, l_b, ext;
  logic            M_ADEL, M_ADES;

  modport master (
    output flush, E_valid, E_I, E_PC, E_AO, E_RD2, E_TAG, M_ready,
    input  E_ready, M_valid, M_I, M_PC, M_AO, M_RD2, M_TAG, M_BE, M_WD,
           s_w, s_h, s_b, l_w, l_h, l_b, ext, M_ADEL, M_ADES
  );

  modport slave (
    input  flush, E_valid, E_I, E_PC, E_AO, E_RD2, E_TAG, M_ready,
    output E_ready, M_valid, M_I, M_PC, M_AO, M_RD2, M_TAG, M_BE, M_WD,
           s_w, s_h, s_b, l_w, l_h, l_b, ext, M_ADEL, M_ADES
  );
endinterface

// File: rtl/mem_stage_reg.sv
// EX->MEM pipeline register as a two-entry skid buffer with load/store width decode.
// Optional misaligned-access flags enabled by defining MEM_STAGE_MISALIGN_CHECK_EN.
module mem_stage_reg #(
  parameter int TAGW = 8,
  parameter int PCW  = 32
) (
  input  logic              clk,
  input  logic              reset,
  mem_stage_reg_if.slave    bus
);
  localparam int EW = 96 + PCW + TAGW;

  logic [EW-1:0]   e_entry;
  logic [EW-1:0]   main_q, main_d, skid_q, skid_d;
  logic            main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic            e_ready, accept;

  logic [31:0]     m_i, m_ao, m_rd2;
  logic [PCW-1:0]  m_pc;
  logic [TAGW-1:0] m_tag;
  logic [5:0]      op;
  logic            is_sw, is_sh, is_sb, is_lw, is_lh, is_lhu, is_lb, is_lbu;
  logic [3:0]      be_raw;
  logic [31:0]     wd;
  logic            adel, ades;

  assign e_entry = {bus.E_I, bus.E_PC, bus.E_AO, bus.E_RD2, bus.E_TAG};
  assign e_ready = reset & ~skid_valid_q;
  assign accept  = bus.E_valid & e_ready;

  // Main drains on M_ready or when empty; skid refills main first so order is kept.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (bus.flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (bus.M_ready || !main_valid_q) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = e_entry;
      end else if (accept) begin
        main_d       = e_entry;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = e_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  // MEM side: everything below is combinational from the main register.
  assign {m_i, m_pc, m_ao, m_rd2, m_tag} = main_q;

  always_comb begin
    op     = m_i[31:26];
    is_sw  = main_valid_q && (op == 6'h2B);
    is_sh  = main_valid_q && (op == 6'h29);
    is_sb  = main_valid_q && (op == 6'h28);
    is_lw  = main_valid_q && (op == 6'h23);
    is_lh  = main_valid_q && (op == 6'h21);
    is_lhu = main_valid_q && (op == 6'h25);
    is_lb  = main_valid_q && (op == 6'h20);
    is_lbu = main_valid_q && (op == 6'h24);

    be_raw = 4'b0000;
    wd     = m_rd2;
    if (is_sw) begin
      be_raw = 4'b1111;
    end else if (is_sh) begin
      be_raw = 4'b0011 << {m_ao[1], 1'b0};
      wd     = {2{m_rd2[15:0]}};
    end else if (is_sb) begin
      be_raw = 4'b0001 << m_ao[1:0];
      wd     = {4{m_rd2[7:0]}};
    end
  end

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
  assign adel = (is_lw && (m_ao[1:0] != 2'b00)) || ((is_lh || is_lhu) && m_ao[0]);
  assign ades = (is_sw && (m_ao[1:0] != 2'b00)) || (is_sh && m_ao[0]);
  assign bus.M_BE = ades ? 4'b0000 : be_raw;
`else
  assign adel = 1'b0;
  assign ades = 1'b0;
  assign bus.M_BE = be_raw;
`endif

  assign bus.E_ready = e_ready;
  assign bus.M_valid = main_valid_q;
  assign bus.M_I     = m_i;
  assign bus.M_PC    = m_pc;
  assign bus.M_AO    = m_ao;
  assign bus.M_RD2   = m_rd2;
  assign bus.M_TAG   = m_tag;
  assign bus.M_WD    = wd;
  assign bus.s_w     = is_sw;
  assign bus.s_h     = is_sh;
  assign bus.s_b     = is_sb;
  assign bus.l_w     = is_lw;
  assign bus.l_h     = is_lh | is_lhu;
  assign bus.l_b     = is_lb | is_lbu;
  assign bus.ext     = is_lh | is_lb;
  assign bus.M_ADEL  = adel;
  assign bus.M_ADES  = ades;
endmodule

// File: doc/mem_stage_reg.md
MEM_STAGE_REG -- requirements
Module: mem_stage_reg

Interface
REQ-001 The block SHALL have parameter TAGW, default 8, giving the width of the sideband tag carried alongside the instruction (destination register, exception code, etc.).
REQ-002 The block SHALL have parameter PCW, default 32, giving the PC field width.
REQ-003 The block SHALL have these ports, each listed as name, direction, width, meaning:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- flush  in  1  discard all held entries.
- E_valid  in  1  EX stage offers an entry.
- E_ready  out  1  block accepts an entry this cycle.
- E_I  in  32  instruction.
- E_PC  in  PCW  program counter.
- E_AO  in  32  ALU result / memory address.
- E_RD2  in  32  store source data.
- E_TAG  in  TAGW  sideband tag.
- M_valid  out  1  output entry is valid.
- M_ready  in  1  MEM stage consumes the entry.
- M_I, M_PC, M_AO, M_RD2, M_TAG  out  32/PCW/32/32/TAGW  registered copies of the entry fields.
- M_BE  out  4  store byte enables.
- M_WD  out  32  lane-aligned store data.
- s_w, s_h, s_b, l_w, l_h, l_b, ext  out  1 each  width-class decode of M_I.
- M_ADEL, M_ADES  out  1 each  misaligned load / store flags (see Configuration).

Function
REQ-004 The block SHALL hold a two-entry elastic buffer, made of a main register (drives the M_* outputs) and a skid register, each with its own valid bit.
REQ-005 E_ready SHALL equal NOT skid_valid, and SHALL be 0 while reset is low.
REQ-006 An accept SHALL occur when E_valid and E_ready are both 1. The accepted entry SHALL go to main if main is empty or M_ready is 1; otherwise it SHALL go to skid.
REQ-007 When M_ready=1 and skid_valid=1, main SHALL load skid on the same edge and skid_valid SHALL clear. In that cycle any new accept SHALL land in skid.
REQ-008 Latency SHALL be 1 cycle when the block is empty: an accept at edge N gives M_valid=1 after edge N.
REQ-009 When M_valid=1 and M_ready=0, the main contents SHALL be held and SHALL NOT change.
REQ-010 M_valid SHALL equal main_valid, and entries SHALL leave in acceptance order.
REQ-011 flush=1 SHALL clear main_valid and skid_valid at the next edge. Flush SHALL win over any simultaneous accept (that entry is dropped) and over any skid-to-main move.
REQ-012 Decode SHALL use the M_I opcode field [31:26]:
- sw=0x2B, sh=0x29, sb=0x28
- lw=0x23, lh=0x21, lhu=0x25, lb=0x20, lbu=0x24
REQ-013 Decode outputs SHALL be s_w=sw, s_h=sh, s_b=sb, l_w=lw, l_h=lh|lhu, l_b=lb|lbu, ext=lh|lb. All of them SHALL be forced to 0 when M_valid=0.
REQ-014 M_BE SHALL be:
- sw: 4'b1111
- sh: 4'b0011 shifted left by 2*M_AO[1]
- sb: 4'b0001 shifted left by M_AO[1:0]
- otherwise, or when M_valid=0: 4'b0000
REQ-015 M_WD SHALL be:
- sw: M_RD2
- sh: {2{M_RD2[15:0]}}
- sb: {4{M_RD2[7:0]}}
- otherwise: M_RD2
REQ-016 Decode, M_BE and M_WD SHALL be combinational from the main register only.

Reset
REQ-017 While reset=0 at a rising edge, the block SHALL clear main_valid, skid_valid and every stored field to 0.
REQ-018 After such a reset, M_valid, M_BE, all decode outputs, M_ADEL and M_ADES SHALL read 0, and E_ready SHALL read 1 once reset=1.
REQ-019 Reset asserted mid-transfer SHALL discard both entries with no partial update.

Configuration
REQ-020 With macro MEM_STAGE_MISALIGN_CHECK_EN defined, the block SHALL drive:
- M_ADEL = M_valid & ((lw & M_AO[1:0]!=0) | ((lh|lhu) & M_AO[0]))
- M_ADES = M_valid & ((sw & M_AO[1:0]!=0) | (sh & M_AO[0]))
- M_BE forced to 4'b0000 whenever M_ADES=1.
REQ-021 Without MEM_STAGE_MISALIGN_CHECK_EN, M_ADEL and M_ADES SHALL be constant 0 and M_BE SHALL follow REQ-014 unconditionally.

Verification
REQ-022 The bench SHALL cover a single sb: E_I opcode 0x28, E_AO=0x1002, E_RD2=0x000000A5, M_ready=1 -> next cycle M_valid=1, M_BE=4'b0100, M_WD=0xA5A5A5A5, s_b=1.
REQ-023 The bench SHALL cover back-pressure: M_ready=0 while three entries are offered on consecutive cycles -> entries 1 and 2 accepted, E_ready=0 on cycle 3; after M_ready=1, entries come out in order 1,2,3 with no loss or duplication.
REQ-024 The bench SHALL cover flush with a full buffer during a simultaneous accept -> M_valid=0 and E_ready=1 next cycle, and the offered entry never appears.
REQ-025 The bench SHALL cover misalignment (macro defined): lw at E_AO=0x2001 -> M_ADEL=1; sh at E_AO=0x3003 -> M_ADES=1 and M_BE=0. With the macro undefined, both flags SHALL stay 0 and the sh gives M_BE=4'b1100.
REQ-026 The bench SHALL cover reset while M_valid=1 and the skid is full: reset=0 for one edge -> all outputs 0, and the next accept appears with 1-cycle latency.
REQ-027 The bench SHALL cover decode: lhu at E_AO=0x0 -> l_h=1, ext=0; lb -> l_b=1, ext=1; addu (opcode 0) -> all decode outputs 0 and M_BE=0.
